attribute_interpolator: RTL and testbench

//  Downstream consumer of the barycentric weight stage.

---
 rtl/attribute_interpolator.sv | 210 +++++++++++++++++++++
 tb/tb_attribute_interpolator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/attribute_interpolator.sv
// Barycentric attribute interpolator: one time-shared MAC step per cycle, saturating per-lane result.
// Optional INTERP_ROUND_EN: round half up instead of floor before the clamp.
module attribute_interpolator #(
  parameter int NUM_ATTR = 4,
  parameter int ATTR_W   = 8,
  parameter int WGT_FRAC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  w0,
  input  logic [31:0]                  w1,
  input  logic [31:0]                  w2,
  input  logic [NUM_ATTR*ATTR_W-1:0]   attr0,
  input  logic [NUM_ATTR*ATTR_W-1:0]   attr1,
  input  logic [NUM_ATTR*ATTR_W-1:0]   attr2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_ATTR*ATTR_W-1:0]   out_attr,
  output logic                         out_sat
);

  localparam int VEC_W  = NUM_ATTR * ATTR_W;
  localparam int ACC_W  = 32 + ATTR_W + 3;
  localparam int LANE_W = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_ATTR - 1);
  localparam logic signed [ACC_W-1:0] LANE_MAX = ACC_W'((64'd1 << ATTR_W) - 64'd1);
`ifdef INTERP_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(64'd1 << (WGT_FRAC - 1));
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic signed [31:0]       w_reg    [3];
  logic [VEC_W-1:0]         attr_reg [3];
  logic signed [ACC_W-1:0]  acc_reg;
  logic [LANE_W-1:0]        lane_reg;
  logic [1:0]               term_reg;
  logic                     sat_acc_reg;
  logic [VEC_W-1:0]         res_reg;
  logic [VEC_W-1:0]         res_next;

  logic signed [31:0]       w_sel;
  logic [VEC_W-1:0]         attr_sel;
  logic [ATTR_W-1:0]        a_sel;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  a_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [ATTR_W-1:0]        lane_val;
  logic                     clamp;
  logic                     last_term;
  logic                     last_lane;

  assign in_ready  = (state_reg == IDLE);
  assign last_term = (term_reg == 2'd2);
  assign last_lane = (lane_reg == LAST_LANE);

  // Operand select: term picks the vertex, lane picks the attribute field.
  always_comb begin
    w_sel    = w_reg[0];
    attr_sel = attr_reg[0];
    case (term_reg)
      2'd1: begin
        w_sel    = w_reg[1];
        attr_sel = attr_reg[1];
      end
      2'd2: begin
        w_sel    = w_reg[2];
        attr_sel = attr_reg[2];
      end
      default: begin
        w_sel    = w_reg[0];
        attr_sel = attr_reg[0];
      end
    endcase
  end

  assign a_sel = attr_sel[lane_reg*ATTR_W +: ATTR_W];
  assign w_ext = ACC_W'(w_sel);
  assign a_ext = ACC_W'({1'b0, a_sel});
  assign prod  = w_ext * a_ext;
  assign sum   = acc_reg + prod;

`ifdef INTERP_ROUND_EN
  assign shifted = (sum + RND_BIAS) >>> WGT_FRAC;
`else
  assign shifted = sum >>> WGT_FRAC;
`endif

  // Saturate the scaled sum into the unsigned lane range.
  always_comb begin
    clamp    = 1'b0;
    lane_val = shifted[ATTR_W-1:0];
    if (shifted[ACC_W-1]) begin
      clamp    = 1'b1;
      lane_val = '0;
    end else if (shifted > LANE_MAX) begin
      clamp    = 1'b1;
      lane_val = '1;
    end
  end

  always_comb begin
    res_next = res_reg;
    if (state_reg == MAC && last_term) begin
      res_next[lane_reg*ATTR_W +: ATTR_W] = lane_val;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (last_term && last_lane) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        w_reg[i]    <= '0;
        attr_reg[i] <= '0;
      end
      acc_reg     <= '0;
      lane_reg    <= '0;
      term_reg    <= '0;
      sat_acc_reg <= 1'b0;
      res_reg     <= '0;
      out_valid   <= 1'b0;
      out_attr    <= '0;
      out_sat     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            w_reg[0]    <= w0;
            w_reg[1]    <= w1;
            w_reg[2]    <= w2;
            attr_reg[0] <= attr0;
            attr_reg[1] <= attr1;
            attr_reg[2] <= attr2;
            acc_reg     <= '0;
            lane_reg    <= '0;
            term_reg    <= '0;
            sat_acc_reg <= 1'b0;
          end
        end
        MAC: begin
          if (last_term) begin
            acc_reg     <= '0;
            term_reg    <= '0;
            res_reg     <= res_next;
            sat_acc_reg <= sat_acc_reg | clamp;
            if (last_lane) begin
              lane_reg  <= '0;
              out_attr  <= res_next;
              out_sat   <= sat_acc_reg | clamp;
              out_valid <= 1'b1;
            end else begin
              lane_reg <= lane_reg + LANE_W'(1);
            end
          end else begin
            acc_reg  <= sum;
            term_reg <= term_reg + 2'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attribute_interpolator.sv
// Randomized self-checking bench for attribute_interpolator against a plain-arithmetic model.
module tb_attribute_interpolator;

  localparam int NA = 4;
  localparam int AW = 8;
  localparam int WF = 16;
  localparam int VW = NA * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   w0 = '0, w1 = '0, w2 = '0;
  logic [VW-1:0] attr0 = '0, attr1 = '0, attr2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_attr;
  logic          out_sat;

  int total = 0;
  int bad   = 0;

  attribute_interpolator #(.NUM_ATTR(NA), .ATTR_W(AW), .WGT_FRAC(WF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .w0(w0), .w1(w1), .w2(w2),
    .attr0(attr0), .attr1(attr1), .attr2(attr2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_attr(out_attr), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: weighted sum in 64-bit integers, floor (or round-half-up) divide, clamp.
  function automatic logic [VW:0] ref_out(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [VW-1:0] x,
                                          input logic [VW-1:0] y, input logic [VW-1:0] z);
    logic [VW-1:0] r;
    logic          s;
    longint        acc;
    longint        q;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < NA; i++) begin
      acc = longint'($signed(a)) * longint'(x[i*AW +: AW])
          + longint'($signed(b)) * longint'(y[i*AW +: AW])
          + longint'($signed(c)) * longint'(z[i*AW +: AW]);
`ifdef INTERP_ROUND_EN
      acc = acc + (longint'(1) <<< (WF - 1));
`endif
      q = acc >>> WF;
      if (q < 0) begin
        q = 0;
        s = 1'b1;
      end else if (q > 255) begin
        q = 255;
        s = 1'b1;
      end
      r[i*AW +: AW] = q[AW-1:0];
    end
    return {s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [VW-1:0] x, input logic [VW-1:0] y, input logic [VW-1:0] z);
    w0 = a; w1 = b; w2 = c;
    attr0 = x; attr1 = y; attr2 = z;
  endtask

  function automatic logic [31:0] rnd_w();
    logic [31:0] m;
    case ($urandom_range(0, 3))
      0: m = $urandom;
      1: m = 32'($urandom_range(0, 32'h0001_0000));
      2: m = -32'($urandom_range(0, 32'h0000_8000));
      default: m = 32'($urandom_range(0, 32'h0000_6000));
    endcase
    return m;
  endfunction

  function automatic logic [VW-1:0] rnd_a();
    return VW'($urandom);
  endfunction

  // Accept the driven set, wait for the result and check latency and data.
  task automatic launch(input string tag);
    logic [VW:0] exp;
    int lat;
    exp = ref_out(w0, w1, w2, attr0, attr1, attr2);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_lat"}, 64'(lat), 64'd12);
    chk({tag, "_attr"}, 64'(out_attr), 64'(exp[VW-1:0]));
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp[VW]));
    $display("txn %s attr=%h sat=%0b lat=%0d", tag, out_attr, out_sat, lat);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_ovl0"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy1"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_set(input string tag);
    launch(tag);
    handshake(tag);
  endtask

  logic [VW:0]   exp_a;
  logic [31:0]   bw [3][3];
  logic [VW-1:0] ba [3][3];
  logic [VW:0]   bexp [3];
  int            tout [3];
  int            got, idx, cyc, seen;
  logic          take;

  initial begin
    // Reset with live-looking inputs that must be ignored
    drive(32'h0001_0000, 0, 0, rnd_a(), rnd_a(), rnd_a());
    in_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ovl", 64'(out_valid), 64'd0);
    chk("rst_attr", 64'(out_attr), 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // T1 identity
    drive(32'h0001_0000, 0, 0, 32'h1122_3344, rnd_a(), rnd_a());
    run_set("t1");
    chk("t1_val", 64'(out_attr), 64'h1122_3344);

    // T2 thirds
    drive(32'h5555, 32'h5555, 32'h5555, {24'h0, 8'd90}, {24'h0, 8'd60}, {24'h0, 8'd30});
    run_set("t2");
`ifdef INTERP_ROUND_EN
    chk("t2_lane0", 64'(out_attr[7:0]), 64'd60);
`else
    chk("t2_lane0", 64'(out_attr[7:0]), 64'd59);
`endif

    // T3 clamps
    drive(32'hFFFF_8000, 0, 0, {24'h0, 8'd100}, rnd_a(), rnd_a());
    run_set("t3lo");
    chk("t3lo_v", 64'({out_sat, out_attr[7:0]}), 64'h100);
    drive(32'h0002_0000, 0, 0, {16'h0, 8'd200, 8'd0}, rnd_a(), rnd_a());
    run_set("t3hi");
    chk("t3hi_v", 64'({out_sat, out_attr[15:8]}), 64'h1FF);

    // T4 backpressure
    out_ready = 1'b0;
    drive(rnd_w(), rnd_w(), rnd_w(), rnd_a(), rnd_a(), rnd_a());
    exp_a = ref_out(w0, w1, w2, attr0, attr1, attr2);
    launch("t4");
    drive(32'h0001_0000, 0, 0, rnd_a(), rnd_a(), rnd_a());
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_ovl", 64'(out_valid), 64'd1);
      chk("t4_hold_rdy", 64'(in_ready), 64'd0);
      chk("t4_hold_attr", 64'(out_attr), 64'(exp_a[VW-1:0]));
    end
    in_valid = 1'b0;
    handshake("t4");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t4_noqueue", 64'(seen), 64'd0);

    // T5 reset mid-MAC
    drive(rnd_w(), rnd_w(), rnd_w(), rnd_a(), rnd_a(), rnd_a());
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rdy", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t5_noout", 64'(seen), 64'd0);
    drive(32'h0001_0000, 0, 0, 32'h1122_3344, rnd_a(), rnd_a());
    run_set("t5_t1");

    // T6 back-to-back with in_valid held high
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 3; j++) begin
        bw[s][j] = rnd_w();
        ba[s][j] = rnd_a();
      end
      bexp[s] = ref_out(bw[s][0], bw[s][1], bw[s][2], ba[s][0], ba[s][1], ba[s][2]);
    end
    out_ready = 1'b1;
    idx = 0;
    got = 0;
    cyc = 0;
    drive(bw[0][0], bw[0][1], bw[0][2], ba[0][0], ba[0][1], ba[0][2]);
    in_valid = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (out_valid) begin
        chk("t6_attr", 64'(out_attr), 64'(bexp[got][VW-1:0]));
        chk("t6_sat", 64'(out_sat), 64'(bexp[got][VW]));
        $display("txn t6.%0d attr=%h sat=%0b cyc=%0d", got, out_attr, out_sat, cyc);
        tout[got] = cyc;
        got++;
      end
      take = in_ready && in_valid;
      tick();
      cyc++;
      if (take) begin
        idx++;
        if (idx < 3) drive(bw[idx][0], bw[idx][1], bw[idx][2], ba[idx][0], ba[idx][1], ba[idx][2]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("t6_count", 64'(got), 64'd3);
    if (got == 3) begin
      chk("t6_gap1", 64'(tout[1] - tout[0]), 64'd14);
      chk("t6_gap2", 64'(tout[2] - tout[1]), 64'd14);
    end
    repeat (2) tick();

    // Random sets
    for (int n = 0; n < 24; n++) begin
      drive(rnd_w(), rnd_w(), rnd_w(), rnd_a(), rnd_a(), rnd_a());
      run_set($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
